// File: rtl/issue_sched_pkg.sv
// Shared constants, tag type and ready-field helper for the issue scheduler.
package issue_sched_pkg;

    localparam int OP_READY_LSB = 9;
    localparam int NUM_OPS      = 4;
    localparam int TAG_W        = 5;

    typedef logic [TAG_W-1:0] tag_t;

    // Takes the instruction bits up to and including the flag field.
    function automatic logic [NUM_OPS-1:0] ready_field(input logic [OP_READY_LSB+NUM_OPS-1:0] low);
        return NUM_OPS'(low >> OP_READY_LSB);
    endfunction

endpackage

// File: rtl/issue_sched_entry.sv
// One reservation-station slot: holds instr + tags, loads from dispatch or the
// next-younger slot, and applies result-bus wakeup to whatever it stores.
module issue_sched_entry
    import issue_sched_pkg::*;
#(
    parameter int INST_WIDTH = 47,
    parameter int TAG_WIDTH  = 5
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           cdb_valid,
    input  logic [TAG_WIDTH-1:0]           cdb_tag,
    input  logic                           load_in,
    input  logic                           load_up,
    input  logic [INST_WIDTH-1:0]          in_instr,
    input  logic [NUM_OPS*TAG_WIDTH-1:0]   in_tags,
    input  logic [INST_WIDTH-1:0]          up_instr,
    input  logic [NUM_OPS*TAG_WIDTH-1:0]   up_tags,
    output logic [INST_WIDTH-1:0]          instr,
    output logic [NUM_OPS*TAG_WIDTH-1:0]   tags,
    output logic                           all_ready
);

    logic [INST_WIDTH-1:0]        instr_q, instr_d, src_instr;
    logic [NUM_OPS*TAG_WIDTH-1:0] tags_q, tags_d, src_tags;

    // Wakeup is applied after the source mux so bypass and shift-wakeup share it.
    always_comb begin
        src_instr = instr_q;
        src_tags  = tags_q;
        if (load_in) begin
            src_instr = in_instr;
            src_tags  = in_tags;
        end else if (load_up) begin
            src_instr = up_instr;
            src_tags  = up_tags;
        end
        instr_d = src_instr;
        tags_d  = src_tags;
        for (int k = 0; k < NUM_OPS; k++) begin
            if (cdb_valid && !src_instr[OP_READY_LSB+k] &&
                src_tags[k*TAG_WIDTH +: TAG_WIDTH] == cdb_tag) begin
                instr_d[OP_READY_LSB+k] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            instr_q <= '0;
            tags_q  <= '0;
        end else begin
            instr_q <= instr_d;
            tags_q  <= tags_d;
        end
    end

    assign instr     = instr_q;
    assign tags      = tags_q;
    assign all_ready = &ready_field(instr_q[OP_READY_LSB+NUM_OPS-1:0]);

endmodule

// File: rtl/issue_sched.sv
// Collapsing-queue reservation station: oldest-ready select and shift control.
// Optional ISSUE_SCHED_FLUSH_EN adds a flush input that empties the station.
module issue_sched
    import issue_sched_pkg::*;
#(
    parameter int INST_WIDTH = 47,
    parameter int TAG_WIDTH  = 5,
    parameter int DEPTH      = 4
) (
    input  logic                           clk,
    input  logic                           rst,
`ifdef ISSUE_SCHED_FLUSH_EN
    input  logic                           flush,
`endif
    input  logic                           in_valid,
    input  logic [INST_WIDTH-1:0]          in_instr,
    input  logic [NUM_OPS*TAG_WIDTH-1:0]   in_tags,
    output logic                           in_ready,
    input  logic                           cdb_valid,
    input  logic [TAG_WIDTH-1:0]           cdb_tag,
    output logic                           out_valid,
    output logic [INST_WIDTH-1:0]          out_instr,
    input  logic                           out_ready,
    output logic [$clog2(DEPTH+1)-1:0]     count
);

    localparam int CW = $clog2(DEPTH+1);
    localparam int SW = $clog2(DEPTH);

    logic                         flush_i;
    logic [CW-1:0]                count_q, count_d, tail;
    logic [INST_WIDTH-1:0]        e_instr  [DEPTH];
    logic [INST_WIDTH-1:0]        up_instr [DEPTH];
    logic [NUM_OPS*TAG_WIDTH-1:0] e_tags   [DEPTH];
    logic [NUM_OPS*TAG_WIDTH-1:0] up_tags  [DEPTH];
    logic [DEPTH-1:0]             e_ready, load_in, load_up;
    logic                         found, do_enq, do_issue;
    logic [SW-1:0]                sel;

`ifdef ISSUE_SCHED_FLUSH_EN
    assign flush_i = flush;
`else
    assign flush_i = 1'b0;
`endif

    always_comb begin
        found = 1'b0;
        sel   = '0;
        for (int i = DEPTH-1; i >= 0; i--) begin
            if (CW'(i) < count_q && e_ready[i]) begin
                found = 1'b1;
                sel   = SW'(i);
            end
        end
    end

    assign in_ready  = (count_q < CW'(DEPTH)) && !flush_i;
    assign out_valid = found && !flush_i;
    assign out_instr = out_valid ? e_instr[sel] : '0;
    assign count     = count_q;
    assign do_enq    = in_valid && in_ready;
    assign do_issue  = out_valid && out_ready;
    // With a same-cycle issue the new entry lands on the post-collapse tail.
    assign tail      = do_issue ? count_q - CW'(1) : count_q;

    always_comb begin
        load_in = '0;
        load_up = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (do_issue && SW'(i) >= sel && i < DEPTH-1) load_up[i] = 1'b1;
            if (do_enq && CW'(i) == tail)                 load_in[i] = 1'b1;
        end
    end

    always_comb begin
        if (flush_i) count_d = '0;
        else         count_d = count_q + CW'(do_enq) - CW'(do_issue);
    end

    always_ff @(posedge clk) begin
        if (rst) count_q <= '0;
        else     count_q <= count_d;
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_slot
        if (g == DEPTH-1) begin : g_last
            assign up_instr[g] = '0;
            assign up_tags[g]  = '0;
        end else begin : g_inner
            assign up_instr[g] = e_instr[g+1];
            assign up_tags[g]  = e_tags[g+1];
        end

        issue_sched_entry #(
            .INST_WIDTH (INST_WIDTH),
            .TAG_WIDTH  (TAG_WIDTH)
        ) u_entry (
            .clk       (clk),
            .rst       (rst),
            .cdb_valid (cdb_valid),
            .cdb_tag   (cdb_tag),
            .load_in   (load_in[g]),
            .load_up   (load_up[g]),
            .in_instr  (in_instr),
            .in_tags   (in_tags),
            .up_instr  (up_instr[g]),
            .up_tags   (up_tags[g]),
            .instr     (e_instr[g]),
            .tags      (e_tags[g]),
            .all_ready (e_ready[g])
        );
    end

endmodule
